// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// codes, FSM state encoding and the funct3 legality check.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Stores only have signed-width encodings; loads add the unsigned variants.
  function automatic logic is_legal_f3(input logic we, input logic [2:0] f3);
    logic legal;
    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) begin
      legal = legal || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return legal;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store merge, byte enables, load extension.
// Misalignment is only flagged when DMEM_MISALIGN_CHECK_EN is defined.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] merged_word,
  output logic [3:0]  byte_en,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] w_wdata_rep;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    byte_en     = 4'b0000;
    w_wdata_rep = wdata;
    case (funct3[1:0])
      2'b00: begin
        byte_en     = 4'b0001 << addr_lo;
        w_wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{wdata[15:0]}};
      end
      2'b10: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      merged_word[i*8 +: 8] = byte_en[i] ? w_wdata_rep[i*8 +: 8] : old_word[i*8 +: 8];
    end
  end

  assign w_byte = old_word[{addr_lo, 3'b000} +: 8];
  assign w_half = addr_lo[1] ? old_word[31:16] : old_word[15:0];

  // funct3[2] selects zero extension for LBU/LHU.
  always_comb begin
    case (funct3[1:0])
      2'b00:   load_data = {{24{w_byte[7] & ~funct3[2]}}, w_byte};
      2'b01:   load_data = {{16{w_half[15] & ~funct3[2]}}, w_half};
      default: load_data = old_word;
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  always_comb begin
    case (funct3[1:0])
      2'b01:   misalign = addr_lo[0];
      2'b10:   misalign = (addr_lo != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with valid/ready request/response and programmable wait
// latency. Optional misalignment errors via DMEM_MISALIGN_CHECK_EN (in dmem_lane_align).
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. Once
// raised, rsp_valid/rsp_rdata/rsp_err hold until their transfer edge.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output dmem_state_t dbg_state
);

  localparam int         AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  dmem_state_t r_state, w_state_nx;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic        r_req_ready, w_req_ready_nx;
  logic        r_rsp_valid, w_rsp_valid_nx;
  logic [31:0] r_rdata, w_rdata_nx;
  logic        r_err, w_err_nx;

  logic          r_we;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [2:0]    r_f3;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_capture;
  logic          w_mem_we;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_old_word;
  logic [31:0]   w_merged;
  logic [3:0]    w_byte_en;
  logic [31:0]   w_load;
  logic          w_misalign;
  logic          w_access_err;

  assign w_idx        = r_addr[AW+1:2];
  assign w_old_word   = r_mem[w_idx];
  assign w_access_err = !is_legal_f3(r_we, r_f3) || w_misalign;

  dmem_lane_align u_lane_align (
    .addr_lo     (r_addr[1:0]),
    .funct3      (r_f3),
    .old_word    (w_old_word),
    .wdata       (r_wdata),
    .merged_word (w_merged),
    .byte_en     (w_byte_en),
    .load_data   (w_load),
    .misalign    (w_misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_req_ready <= w_req_ready_nx;
      r_rsp_valid <= w_rsp_valid_nx;
      r_rdata     <= w_rdata_nx;
      r_err       <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_req_ready_nx = r_req_ready;
    w_rsp_valid_nx = r_rsp_valid;
    w_rdata_nx     = r_rdata;
    w_err_nx       = r_err;
    w_capture      = 1'b0;
    w_mem_we       = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready_nx = 1'b1;
        if (req_valid && r_req_ready) begin
          w_capture      = 1'b1;
          w_req_ready_nx = 1'b0;
          w_cnt_nx       = LAT4;
          w_state_nx     = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_mem_we       = r_we && !w_access_err;
          w_rsp_valid_nx = 1'b1;
          w_err_nx       = w_access_err;
          w_rdata_nx     = (r_we || w_access_err) ? 32'd0 : w_load;
          w_state_nx     = RESP;
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nx = 1'b0;
          w_rdata_nx     = 32'd0;
          w_err_nx       = 1'b0;
          w_req_ready_nx = 1'b1;
          w_state_nx     = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_we    <= req_we;
      r_addr  <= req_addr[AW+1:0];
      r_wdata <= req_wdata;
      r_f3    <= req_funct3;
    end
  end

  // The array is not reset, but a reset edge must still suppress a pending store.
  always_ff @(posedge clk) begin
    if (!reset && w_mem_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=1, DEPTH_WORDS=256);
// the misalignment scenario follows DMEM_MISALIGN_CHECK_EN.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  dmem_state_t dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: one full request/response; scrambles req_* after accept.
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, output logic [31:0] rd, output logic e,
                      output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL req_ready_timeout got=%0b want=1", req_ready);
    end
    req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1)); req_addr = $urandom; req_wdata = $urandom;
    req_funct3 = 3'($urandom_range(0, 7));
    lat = 0;
    while (!rsp_valid && lat < 50) begin tick(); lat++; end
    if (!rsp_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_valid_timeout got=%0b want=1", rsp_valid);
    end
    rd = rsp_rdata; e = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got=%0b want=0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%0b want=0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got=%h want=0", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b want=0", rsp_err); end
    n_cmp++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE); end
    reset = 1'b0;
    tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got=%0b want=1", req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 32'h10, 32'hDEADBEEF, F3_W, rd, e, lat);
    n_cmp++; if (lat !== 1 + LAT) begin n_fail++; $display("FAIL sw_latency got=%0d want=%0d", lat, 1 + LAT); end
    n_cmp++; if (rd !== 32'd0 || e !== 1'b0) begin n_fail++; $display("FAIL sw_rsp got=%h/%0b want=0/0", rd, e); end
    xact(1'b0, 32'h10, 32'h0, F3_W, rd, e, lat);
    n_cmp++; if (lat !== 1 + LAT) begin n_fail++; $display("FAIL lw_latency got=%0d want=%0d", lat, 1 + LAT); end
    n_cmp++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin n_fail++; $display("FAIL lw_word got=%h/%0b want=deadbeef/0", rd, e); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 32'h10, 32'h11223344, F3_W, rd, e, lat);
    xact(1'b1, 32'h13, 32'hAAAAAA80, F3_B, rd, e, lat);
    xact(1'b0, 32'h10, 32'h0, F3_W, rd, e, lat);
    n_cmp++; if (rd !== 32'h80223344) begin n_fail++; $display("FAIL sb_merge got=%h want=80223344", rd); end
    xact(1'b0, 32'h13, 32'h0, F3_B, rd, e, lat);
    n_cmp++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_sext got=%h want=ffffff80", rd); end
    xact(1'b0, 32'h13, 32'h0, F3_BU, rd, e, lat);
    n_cmp++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_zext got=%h want=00000080", rd); end
    xact(1'b0, 32'h11, 32'h0, F3_B, rd, e, lat);
    n_cmp++; if (rd !== 32'h00000033) begin n_fail++; $display("FAIL lb_lane1 got=%h want=00000033", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic e; int lat;
    xact(1'b0, 32'h12, 32'h0, F3_H, rd, e, lat);
    n_cmp++; if (rd !== 32'hFFFF8022) begin n_fail++; $display("FAIL lh_hi got=%h want=ffff8022", rd); end
    xact(1'b0, 32'h12, 32'h0, F3_HU, rd, e, lat);
    n_cmp++; if (rd !== 32'h00008022) begin n_fail++; $display("FAIL lhu_hi got=%h want=00008022", rd); end
    xact(1'b0, 32'h10, 32'h0, F3_H, rd, e, lat);
    n_cmp++; if (rd !== 32'h00003344) begin n_fail++; $display("FAIL lh_lo got=%h want=00003344", rd); end
    xact(1'b1, 32'h10, 32'hCAFEBEEF, F3_H, rd, e, lat);
    xact(1'b0, 32'h10, 32'h0, F3_W, rd, e, lat);
    n_cmp++; if (rd !== 32'h8022BEEF) begin n_fail++; $display("FAIL sh_merge got=%h want=8022beef", rd); end
    xact(1'b1, 32'h10, 32'h01010101, F3_BU, rd, e, lat);
    n_cmp++; if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL st_illegal got=%h/%0b want=0/1", rd, e); end
    xact(1'b0, 32'h10, 32'h0, F3_W, rd, e, lat);
    n_cmp++; if (rd !== 32'h8022BEEF || e !== 1'b0) begin n_fail++; $display("FAIL st_illegal_nowrite got=%h/%0b want=8022beef/0", rd, e); end
    xact(1'b0, 32'h10, 32'h0, 3'b011, rd, e, lat);
    n_cmp++; if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL ld_illegal_011 got=%h/%0b want=0/1", rd, e); end
    xact(1'b0, 32'h10, 32'h0, 3'b110, rd, e, lat);
    n_cmp++; if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL ld_illegal_110 got=%h/%0b want=0/1", rd, e); end
  endtask

  task automatic test_backpressure();
    int n;
    req_we = 1'b0; req_addr = 32'h10; req_funct3 = F3_W; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8022BEEF || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d got=v%0b/%h/r%0b want=v1/8022beef/r0", k, rsp_valid, rsp_rdata, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL release got=v%0b/r%0b/%h want=v0/r1/0", rsp_valid, req_ready, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int prev; int gaps; int n;
    prev = -1; gaps = 0;
    req_we = 1'b0; req_addr = 32'h10; req_funct3 = F3_W;
    rsp_ready = 1'b1; req_valid = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (req_ready) begin
        if (prev >= 0) begin
          n_cmp++;
          if (k - prev !== 3 + LAT) begin n_fail++; $display("FAIL b2b_gap got=%0d want=%0d", k - prev, 3 + LAT); end
          gaps++;
        end
        prev = k;
      end
      if (rsp_valid) begin
        n_cmp++;
        if (rsp_rdata !== 32'h8022BEEF) begin n_fail++; $display("FAIL b2b_rdata got=%h want=8022beef", rsp_rdata); end
      end
      tick();
    end
    req_valid = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    rsp_ready = 1'b0;
    n_cmp++;
    if (gaps !== 3) begin n_fail++; $display("FAIL b2b_count got=%0d want=3", gaps); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 32'h20, 32'h0000A5A5, F3_W, rd, e, lat);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55; req_funct3 = F3_W; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n_cmp++; if (dbg_state !== WAIT) begin n_fail++; $display("FAIL wait_entered got=%0d want=%0d", dbg_state, WAIT); end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_in_wait got=r%0b/v%0b/s%0d want=r0/v0/s0", req_ready, rsp_valid, dbg_state);
    end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got=%0b want=1", req_ready); end
    xact(1'b0, 32'h20, 32'h0, F3_W, rd, e, lat);
    n_cmp++; if (rd !== 32'h0000A5A5) begin n_fail++; $display("FAIL store_discarded got=%h want=0000a5a5", rd); end
  endtask

  task automatic test_wrap_misalign();
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 32'h0, 32'h0BADF00D, F3_W, rd, e, lat);
    xact(1'b0, 32'h400, 32'h0, F3_W, rd, e, lat);
    n_cmp++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL wrap_load got=%h want=0badf00d", rd); end
    xact(1'b1, 32'hFFFF_F404, 32'h76543210, F3_W, rd, e, lat);
    xact(1'b0, 32'h4, 32'h0, F3_W, rd, e, lat);
    n_cmp++; if (rd !== 32'h76543210) begin n_fail++; $display("FAIL wrap_store got=%h want=76543210", rd); end
    xact(1'b1, 32'h21, 32'h12345678, F3_W, rd, e, lat);
`ifdef DMEM_MISALIGN_CHECK_EN
    n_cmp++; if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL sw_misalign_err got=%h/%0b want=0/1", rd, e); end
    xact(1'b0, 32'h20, 32'h0, F3_W, rd, e, lat);
    n_cmp++; if (rd !== 32'h0000A5A5) begin n_fail++; $display("FAIL sw_misalign_nowrite got=%h want=0000a5a5", rd); end
    xact(1'b0, 32'h11, 32'h0, F3_H, rd, e, lat);
    n_cmp++; if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL lh_misalign got=%h/%0b want=0/1", rd, e); end
`else
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL sw_unaligned_err got=%0b want=0", e); end
    xact(1'b0, 32'h20, 32'h0, F3_W, rd, e, lat);
    n_cmp++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL sw_unaligned_write got=%h want=12345678", rd); end
    xact(1'b0, 32'h23, 32'h0, F3_H, rd, e, lat);
    n_cmp++; if (rd !== 32'h00001234 || e !== 1'b0) begin n_fail++; $display("FAIL lh_unaligned got=%h/%0b want=00001234/0", rd, e); end
`endif
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_backpressure();
    test_back_to_back();
    test_reset_in_wait();
    test_wrap_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
